// File: rtl/sdf_query_engine_pkg.sv
// sdf_query_engine_pkg: fixed-point types, scene modes, FSM states and the
// small arithmetic helpers shared by the query engine and its fold datapath.
package sdf_query_engine_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_FRAC  = 16;

    typedef logic signed [FP_WIDTH-1:0] fp_t;

    // x occupies the most significant word of a flattened vec3
    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    typedef enum logic [1:0] {
        SDF_CUBE       = 2'd0,
        SDF_SPONGE     = 2'd1,
        SDF_SPONGE_INF = 2'd2,
        SDF_RESERVED   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOX,
        ST_ITER,
        ST_DONE
    } state_t;

    localparam fp_t FP_ONE    = fp_t'(1 << FP_FRAC);
    localparam fp_t FP_HALF   = fp_t'(1 << (FP_FRAC - 1));
    localparam fp_t FP_MIN    = fp_t'({1'b1, {(FP_WIDTH-1){1'b0}}});
    localparam fp_t MOD2_MASK = fp_t'((1 << (FP_FRAC + 1)) - 1);

    function automatic fp_t fp_abs(input fp_t x);
        return x[FP_WIDTH-1] ? -x : x;
    endfunction

    function automatic fp_t fp_max(input fp_t a, input fp_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic fp_t fp_min(input fp_t a, input fp_t b);
        return (a < b) ? a : b;
    endfunction

    // Floored mod 2: the low FP_FRAC+1 bits read as unsigned land in [0,2)
    function automatic fp_t fp_mod2(input fp_t x);
        return x & MOD2_MASK;
    endfunction

    // Full-width product, then an arithmetic shift, which rounds toward -inf
    function automatic fp_t fp_mul(input fp_t a, input fp_t b);
        logic signed [2*FP_WIDTH-1:0] p;
        p = {{FP_WIDTH{a[FP_WIDTH-1]}}, a} * {{FP_WIDTH{b[FP_WIDTH-1]}}, b};
        return fp_t'(p >>> FP_FRAC);
    endfunction

    // Per-axis cross distance inside one sponge cell: |1 - 3|q - 1||
    function automatic fp_t fold_r(input fp_t q);
        fp_t a;
        fp_t t;
        a = fp_abs(q - FP_ONE);
        t = FP_ONE - (a + (a <<< 1));
        return fp_abs(t);
    endfunction

    // Round-to-nearest of 2^FP_FRAC / 3^k, evaluated at elaboration time
    function automatic fp_t inv3_pow(input int k);
        longint p3;
        longint num;
        p3 = 1;
        for (int i = 0; i < k; i++) begin
            p3 = p3 * 3;
        end
        num = (longint'(1) << (FP_FRAC + 1)) + p3;
        return fp_t'(num / (2 * p3));
    endfunction

endpackage

// File: rtl/sdf_sponge_fold.sv
// sdf_sponge_fold: one Menger-sponge fold step. Maps the cell coordinate q,
// running distance d and scale index k to the next q and d. The 3^k scale is
// carried implicitly by q and the 1/3^k table, never formed as a number.
module sdf_sponge_fold
    import sdf_query_engine_pkg::*;
#(
    parameter int MAX_ITERS = 4,
    parameter int ITER_W    = $clog2(MAX_ITERS + 1)
) (
    input  logic [3*FP_WIDTH-1:0] q,
    input  logic [FP_WIDTH-1:0]   d,
    input  logic [ITER_W-1:0]     k,
    output logic [3*FP_WIDTH-1:0] q_next,
    output logic [FP_WIDTH-1:0]   d_next
);

    fp_t               inv3_table [MAX_ITERS+1];
    vec3_t             qv;
    vec3_t             qn;
    fp_t               rx;
    fp_t               ry;
    fp_t               rz;
    fp_t               med;
    fp_t               c;
    logic [ITER_W-1:0] k_plus;

    for (genvar i = 0; i <= MAX_ITERS; i++) begin : g_inv3
        assign inv3_table[i] = inv3_pow(i);
    end

    // Carve the cross hole at this scale and step q to the next finer cell
    always_comb begin
        qv     = vec3_t'(q);
        rx     = fold_r(qv.x);
        ry     = fold_r(qv.y);
        rz     = fold_r(qv.z);
        med    = fp_min(fp_min(fp_max(rx, ry), fp_max(ry, rz)), fp_max(rz, rx));
        k_plus = k + ITER_W'(1);
        c      = fp_mul(med - FP_ONE, inv3_table[k_plus]);
        d_next = fp_max(fp_t'(d), c);
        qn.x   = fp_mod2(qv.x + (qv.x <<< 1));
        qn.y   = fp_mod2(qv.y + (qv.y <<< 1));
        qn.z   = fp_mod2(qv.z + (qv.z <<< 1));
        q_next = qn;
    end

endmodule

// File: rtl/sdf_query_engine.sv
// sdf_query_engine: single-entry multi-cycle signed-distance query unit.
// Accepts a point on valid/ready, evaluates the bounding box, then applies
// one sponge fold per clock before presenting the distance and tag.
module sdf_query_engine
    import sdf_query_engine_pkg::*;
#(
    parameter int MAX_ITERS = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    input  logic [3*FP_WIDTH-1:0]          point_in,
    input  logic [1:0]                     mode_in,
    input  logic [$clog2(MAX_ITERS+1)-1:0] iters_in,
    input  logic [TAG_WIDTH-1:0]           tag_in,
    output logic                           valid_out,
    input  logic                           ready_in,
    output logic [FP_WIDTH-1:0]            sdf_out,
    output logic [TAG_WIDTH-1:0]           tag_out
);

    localparam int ITER_W = $clog2(MAX_ITERS + 1);

    state_t                state;
    state_t                state_next;
    vec3_t                 point_r;
    mode_t                 mode_r;
    logic [ITER_W-1:0]     iters_r;
    logic [ITER_W-1:0]     iters_clamped;
    logic [ITER_W-1:0]     k_r;
    logic [TAG_WIDTH-1:0]  tag_r;
    fp_t                   d_r;
    vec3_t                 q_r;
    logic                  is_sponge;
    logic                  box_to_done;
    logic                  last_iter;
    logic                  accept;
    logic                  deliver;
    logic                  retire;
    fp_t                   h;
    fp_t                   box_d;
    vec3_t                 box_q;
    logic [3*FP_WIDTH-1:0] fold_q;
    logic [FP_WIDTH-1:0]   fold_d;

    assign iters_clamped = (iters_in > ITER_W'(MAX_ITERS)) ? ITER_W'(MAX_ITERS) : iters_in;

    sdf_sponge_fold #(
        .MAX_ITERS (MAX_ITERS),
        .ITER_W    (ITER_W)
    ) u_fold (
        .q      (q_r),
        .d      (d_r),
        .k      (k_r),
        .q_next (fold_q),
        .d_next (fold_d)
    );

    // Bounding-box distance and initial cell coordinate from the latched point
    always_comb begin
        is_sponge   = (mode_r == SDF_SPONGE) || (mode_r == SDF_SPONGE_INF);
        h           = is_sponge ? FP_ONE : FP_HALF;
        box_d       = fp_max(fp_max(fp_abs(point_r.x) - h, fp_abs(point_r.y) - h),
                             fp_abs(point_r.z) - h);
        if (mode_r == SDF_SPONGE_INF) begin
            box_d = FP_MIN;
        end
        box_q.x     = fp_mod2(point_r.x);
        box_q.y     = fp_mod2(point_r.y);
        box_q.z     = fp_mod2(point_r.z);
        // A zero iteration count skips the fold loop for either sponge mode
        box_to_done = !is_sponge || (iters_r == '0);
        // k doubles as the completed-iteration count
        last_iter   = (k_r == iters_r - ITER_W'(1));
    end

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (valid_in)               state_next = ST_BOX;
            ST_BOX:  state_next = box_to_done ? ST_DONE : ST_ITER;
            ST_ITER: if (last_iter)              state_next = ST_DONE;
            ST_DONE: if (valid_out && ready_in)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake and datapath enables
    always_comb begin
        ready_out = (state == ST_IDLE);
        accept    = valid_in && ready_out;
        deliver   = (state == ST_DONE) && !valid_out;
        retire    = (state == ST_DONE) && valid_out && ready_in;
    end

    // Query registers, running distance/cell state and the output holding register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            point_r   <= '0;
            mode_r    <= SDF_CUBE;
            iters_r   <= '0;
            tag_r     <= '0;
            d_r       <= '0;
            q_r       <= '0;
            k_r       <= '0;
            valid_out <= 1'b0;
            sdf_out   <= '0;
            tag_out   <= '0;
        end else begin
            if (accept) begin
                point_r <= vec3_t'(point_in);
                mode_r  <= mode_t'(mode_in);
                iters_r <= iters_clamped;
                tag_r   <= tag_in;
            end
            if (state == ST_BOX) begin
                d_r <= box_d;
                q_r <= box_q;
                k_r <= '0;
            end
            if (state == ST_ITER) begin
                d_r <= fp_t'(fold_d);
                q_r <= vec3_t'(fold_q);
                k_r <= k_r + ITER_W'(1);
            end
            if (deliver) begin
                valid_out <= 1'b1;
                sdf_out   <= d_r;
                tag_out   <= tag_r;
            end else if (retire) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sdf_query_engine.md
Name: sdf_query_engine

Overview:
- Multi-cycle signed-distance query unit for the ray marcher.
- Supports three runtime-selectable scenes: a cube, a Menger sponge with N iterations, and an infinite tiled sponge.
- Uses a valid/ready handshake and runs one sponge fold per clock, so the marcher can trade latency against fractal depth.
- Sits between the march-step controller and the hit/normal logic; carries an opaque tag through for out-of-band bookkeeping.

Parameters:
- MAX_ITERS, 4: largest sponge iteration count supported; sizes the iteration counter and the 1/3^k constant table.
- TAG_WIDTH, 8: width of the pass-through tag.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- valid_in  in  1  query present
- ready_out  out  1  engine can accept a query
- point_in  in  vec3  query point (3 x fp)
- mode_in  in  2  0=cube, 1=sponge, 2=sponge_inf, 3=reserved (treated as cube)
- iters_in  in  $clog2(MAX_ITERS+1)  sponge iterations; values above MAX_ITERS clamp to MAX_ITERS
- tag_in  in  TAG_WIDTH  opaque tag
- valid_out  out  1  result present
- ready_in  in  1  consumer accepts result
- sdf_out  out  fp  distance
- tag_out  out  TAG_WIDTH  tag of this result

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-high.
- Reset values: state=IDLE, ready_out=1, valid_out=0, sdf_out=0, tag_out=0.
- Arithmetic: fp is FP_WIDTH two's complement with FP_FRAC fraction bits. Multiplies truncate toward negative infinity.
- Single-entry engine; no new query is accepted while one is in flight.
- FSM states:
  - IDLE: ready_out=1. On valid_in&&ready_out, latch point, mode, clamped iters and tag; go to BOX.
  - BOX (1 cycle): d = max_i(|p_i| - h), with h=0.5 for cube and h=1.0 for sponge. For sponge_inf, d = FP_MIN (most negative fp). Initialise q_i = mod(p_i, 2), inv index k=0, count=0. If mode is cube, or iters==0 with mode sponge, go to DONE; otherwise go to ITER.
  - ITER (1 cycle per iteration):
    - a_i = q_i - 1; r_i = |1 - 3|a_i||.
    - c = (min(max(rx,ry), max(ry,rz), max(rz,rx)) - 1) * INV3_POW[k+1].
    - d = max(d, c); q_i = mod(3*q_i, 2); k++.
    - Go to DONE when count == iters-1.
  - DONE: valid_out=1 with sdf_out=d and tag_out=tag. On ready_in, go to IDLE. sdf_out and tag_out stay stable while valid_out && !ready_in.
- mod(x,2): keep the low FP_FRAC+1 bits as unsigned (floored mod, result in [0,2)). This is exact for negative inputs and for any |p|, so the infinite sponge never overflows.
- The ITER scale factor 3^k is never formed explicitly; only q and the INV3_POW table are used.
- Latency, with the accepting edge as E0:
  - cube: valid_out high after edge E0+2.
  - sponge with n≥1 iterations: valid_out high after edge E0+2+n.
  - sponge with n=0: same as cube.
- ready_out is low from E0 until the cycle after the result handshake; no back-to-back overlap.
- Reset mid-operation: the in-flight query is discarded with no output; the engine returns to IDLE immediately.
- Inputs are ignored while ready_out is low.

Decomposition:
- Shared package (types.sv / sdf_primitives.sv) holds: FP_WIDTH=32, FP_FRAC=16, the fp and vec3 typedefs, the mode enum (SDF_CUBE, SDF_SPONGE, SDF_SPONGE_INF), and the INV3_POW[0..MAX_ITERS] constant function (round-to-nearest of 2^FP_FRAC/3^k).
- One natural sub-module, sdf_sponge_fold: combinational ITER datapath mapping (q, d, k) to (q_next, d_next).
- The FSM, handshake and registers stay in sdf_query_engine.

Test Plan:
- Cube, point (0,0,0) -> after E0+2, valid_out=1, sdf_out=0xFFFF8000 (-0.5); tag echoed.
- Cube, point (1.5,-0.25,0.5) -> sdf_out=0x00010000 (1.0). Mode 3 with the same point gives an identical result.
- Sponge, iters=0, point (2,0,0) -> sdf_out=0x00010000 at E0+2. Sponge, iters=1, point (0,0,0) -> sdf_out=0x00005555 (≈1/3, centre hole) at E0+3.
- Sponge_inf, iters=1, points (0,0,0) and (-8,4,100) -> both give sdf_out=0x00005555, confirming periodicity and negative mod. iters=7 clamps to 4, giving latency E0+6.
- Backpressure: hold ready_in=0 for 5 cycles -> valid_out, sdf_out and tag_out stable; ready_out=0; a second valid_in is ignored; ready_out returns 1 the cycle after the handshake.
- Assert rst_in asynchronously during ITER of a 4-iteration query -> valid_out=0 and ready_out=1 immediately. No stale result appears afterwards, and the next query returns the correct value.
